// File: rtl/divu_hilo_pkg.sv
// Shared ALU function codes for the ALU control block and the HI/LO divider.
// Any block decoding Signal imports these instead of redefining them.
package divu_hilo_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_OUT  = 6'b111111;

endpackage

// File: rtl/divu_hilo_hilo_reg.sv
// Architectural HI/LO register pair, written together on a single enable.
module hilo_reg
  import divu_hilo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN-1:0] r_hi, r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (we) begin
      r_hi <= hi_in;
      r_lo <= lo_in;
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: rtl/divu_hilo.sv
// Multi-cycle unsigned restoring divider that commits remainder/quotient into HI/LO.
// One quotient bit per DIVU edge; results reach HI/LO only on an OUT edge in DONE.
module divu_hilo
  import divu_hilo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      Signal,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic [XLEN-1:0] dataOut,
  output logic            busy,
  output logic            divZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic            w_load, w_step, w_commit;
  logic [4:0]      r_cnt;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo, r_div;
  logic            r_div_zero;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_borrow, w_ge;
  logic [XLEN-1:0] w_hi, w_lo;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: if (Signal == OP_DIVU) begin
        w_load = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: if (Signal == OP_DIVU) begin
        w_step = 1'b1;
        if (r_cnt == 5'd31) w_next = S_DONE;
      end else begin
        w_next = S_IDLE;
      end
      S_DONE: if (Signal == OP_OUT) begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end else if (Signal != OP_DIVU) begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shifted partial remainder is {r_rem, quotient MSB}; its top bit (r_rem[32])
  // set means it certainly exceeds the divisor, otherwise the 33-bit subtract decides.
  assign w_shift            = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge               = r_rem[XLEN] | ~w_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= dataA;
      r_div <= dataB;
    end else if (w_step) begin
      r_cnt <= r_cnt + 5'd1;
      r_rem <= w_ge ? w_diff : w_shift;
      r_quo <= {r_quo[XLEN-2:0], w_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_div_zero <= 1'b0;
    else if (w_commit) r_div_zero <= (r_div == '0);
  end

  hilo_reg u_hilo (
    .clk    (clk),
    .rst    (rst),
    .we     (w_commit),
    .hi_in  (r_rem[XLEN-1:0]),
    .lo_in  (r_quo),
    .hi_out (w_hi),
    .lo_out (w_lo)
  );

  always_comb begin
    dataOut = '0;
    if (Signal == OP_MFHI)      dataOut = w_hi;
    else if (Signal == OP_MFLO) dataOut = w_lo;
  end

  assign busy    = (r_state != S_IDLE);
  assign divZero = r_div_zero;

endmodule

// File: tb/tb_divu_hilo.sv
// Scoreboard bench for divu_hilo: expected HI/LO/divZero queued at stimulus, checked after commit.
module tb_divu_hilo;
  import divu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB, dataOut;
  logic        busy, divZero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hi, lo;

  divu_hilo dut (
    .clk(clk), .rst(rst), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .dataOut(dataOut), .busy(busy), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    if (b == 32'd0) m = '{hi: a, lo: 32'hFFFFFFFF, dz: 1'b1};
    else            m = '{hi: a % b, lo: a / b, dz: 1'b0};
    return m;
  endfunction

  // DIVU for n edges; operands are scrambled after the load edge.
  task automatic run_divu(input logic [31:0] a, input logic [31:0] b, input int n);
    Signal = OP_DIVU; dataA = a; dataB = b;
    tick;
    dataA = ~a; dataB = b ^ 32'h5A5A_0001;
    repeat (n - 1) tick;
  endtask

  task automatic commit;
    Signal = OP_OUT;
    tick;
    Signal = OP_SLL;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    Signal = OP_MFHI; #1 h = dataOut;
    Signal = OP_MFLO; #1 l = dataOut;
    Signal = OP_SLL;  #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; Signal = OP_DIVU; dataA = 32'd9; dataB = 32'd2;
    tick; tick;
    rst = 1'b0; Signal = OP_SLL;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_chk++; if (divZero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b want=0", divZero); end
    read_hilo(hi, lo);
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", hi); end
    n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", lo); end
  endtask

  task automatic test_divide;
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    run_divu(32'd100, 32'd7, 33);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy_done got=%b want=1", busy); end
    commit;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div_busy_after got=%b want=0", busy); end
    e = sb.pop_front();
    read_hilo(hi, lo);
    n_chk++; if (hi !== e.hi) begin n_fail++; $display("FAIL div_hi got=%h want=%h", hi, e.hi); end
    n_chk++; if (lo !== e.lo) begin n_fail++; $display("FAIL div_lo got=%h want=%h", lo, e.lo); end
    n_chk++; if (divZero !== e.dz) begin n_fail++; $display("FAIL div_dz got=%b want=%b", divZero, e.dz); end
    Signal = OP_ADD; #1;
    n_chk++; if (dataOut !== 32'd0) begin n_fail++; $display("FAIL dataout_other got=%h want=0", dataOut); end
    Signal = OP_SLL;
  endtask

  task automatic test_div_zero;
    sb.push_back('{hi: 32'h12345678, lo: 32'hFFFFFFFF, dz: 1'b1});
    run_divu(32'h12345678, 32'd0, 33);
    commit;
    e = sb.pop_front();
    read_hilo(hi, lo);
    n_chk++; if (hi !== e.hi) begin n_fail++; $display("FAIL dz_hi got=%h want=%h", hi, e.hi); end
    n_chk++; if (lo !== e.lo) begin n_fail++; $display("FAIL dz_lo got=%h want=%h", lo, e.lo); end
    n_chk++; if (divZero !== e.dz) begin n_fail++; $display("FAIL dz_flag got=%b want=%b", divZero, e.dz); end
  endtask

  task automatic test_full_width;
    sb.push_back('{hi: 32'd0, lo: 32'hFFFFFFFF, dz: 1'b0});
    sb.push_back('{hi: 32'd1, lo: 32'd3, dz: 1'b0});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_divu(32'hFFFFFFFF, 32'd1, 33);
      else        run_divu(32'd10, 32'd3, 33);
      commit;
      e = sb.pop_front();
      read_hilo(hi, lo);
      n_chk++; if (hi !== e.hi) begin n_fail++; $display("FAIL fw_hi[%0d] got=%h want=%h", k, hi, e.hi); end
      n_chk++; if (lo !== e.lo) begin n_fail++; $display("FAIL fw_lo[%0d] got=%h want=%h", k, lo, e.lo); end
      n_chk++; if (divZero !== e.dz) begin n_fail++; $display("FAIL fw_dz[%0d] got=%b want=%b", k, divZero, e.dz); end
    end
  endtask

  task automatic test_abort;
    run_divu(32'd500, 32'd9, 14);
    Signal = OP_ADD;
    tick;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
    Signal = OP_OUT; tick; tick;
    read_hilo(hi, lo);
    n_chk++; if (hi !== 32'd1) begin n_fail++; $display("FAIL abort_hi got=%h want=1", hi); end
    n_chk++; if (lo !== 32'd3) begin n_fail++; $display("FAIL abort_lo got=%h want=3", lo); end
    sb.push_back('{hi: 32'd10, lo: 32'd30, dz: 1'b0});
    run_divu(32'd1000, 32'd33, 33);
    commit;
    e = sb.pop_front();
    read_hilo(hi, lo);
    n_chk++; if (hi !== e.hi) begin n_fail++; $display("FAIL abort_rerun_hi got=%h want=%h", hi, e.hi); end
    n_chk++; if (lo !== e.lo) begin n_fail++; $display("FAIL abort_rerun_lo got=%h want=%h", lo, e.lo); end
  endtask

  task automatic test_reset_mid_run;
    run_divu(32'd777, 32'd5, 19);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_busy got=%b want=0", busy); end
    read_hilo(hi, lo);
    n_chk++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rstrun_hilo got=%h/%h want=0/0", hi, lo); end
    Signal = OP_OUT; repeat (3) tick;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_out_busy got=%b want=0", busy); end
    read_hilo(hi, lo);
    n_chk++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rstrun_out_hilo got=%h/%h want=0/0", hi, lo); end
    // reset coinciding with the OUT edge in DONE must not commit
    run_divu(32'd50, 32'd0, 33);
    Signal = OP_OUT; rst = 1'b1;
    tick;
    rst = 1'b0; Signal = OP_SLL;
    read_hilo(hi, lo);
    n_chk++; if (hi !== 32'd0 || lo !== 32'd0 || divZero !== 1'b0) begin
      n_fail++; $display("FAIL rstdone got=%h/%h/%b want=0/0/0", hi, lo, divZero);
    end
  endtask

  task automatic test_persistent_out;
    sb.push_back('{hi: 32'd2, lo: 32'd15, dz: 1'b0});
    run_divu(32'd77, 32'd5, 33);
    Signal = OP_OUT;
    tick;
    for (int k = 0; k < 5; k++) begin
      dataA = $urandom; dataB = $urandom;
      tick;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pout_busy[%0d] got=%b want=0", k, busy); end
    end
    e = sb.pop_front();
    read_hilo(hi, lo);
    n_chk++; if (hi !== e.hi || lo !== e.lo) begin
      n_fail++; $display("FAIL pout_hilo got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      case (k)
        0: b = 32'd0;
        1: b = a;
        2: b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      sb.push_back(model(a, b));
      run_divu(a, b, 33);
      commit;
      e = sb.pop_front();
      read_hilo(hi, lo);
      n_chk++; if (hi !== e.hi || lo !== e.lo || divZero !== e.dz) begin
        n_fail++;
        $display("FAIL b2b[%0d] %h/%h got=%h/%h/%b want=%h/%h/%b", k, a, b, hi, lo, divZero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  initial begin
    rst = 1'b0; Signal = OP_SLL; dataA = '0; dataB = '0;
    test_reset;
    test_divide;
    test_div_zero;
    test_full_width;
    test_abort;
    test_reset_mid_run;
    test_persistent_out;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
